// File: rtl/decode_sequencer.sv
// decode_sequencer: registered, handshaked EV22 instruction decoder.
// One instruction is accepted per handshake and produces a one-cycle ctrl_valid
// pulse with a held control word. MOM instructions keep MR/MW asserted for
// MEM_CYCLES cycles. Optional macro EV22_CALL_STACK_EN adds the BSR/RET
// return-address stack and the sticky stack_err flag.
module decode_sequencer #(
    parameter int RW          = 5,
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4,
    parameter int MEM_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [7:0]      OPCODE,
    input  logic [RW-1:0]   Ri,
    input  logic [RW-1:0]   Rj,
    input  logic [PC_W-1:0] pc,
    output logic            ctrl_valid,
    output logic [3:0]      ALUC,
    output logic [1:0]      SH,
    output logic            KMux,
    output logic            MR,
    output logic            MW,
    output logic [RW-1:0]   Sel_A,
    output logic [RW:0]     Sel_B,
    output logic [RW:0]     Sel_C,
    output logic [6:0]      Type,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_target,
    output logic            illegal,
    output logic            stack_err
);

    localparam logic [RW:0] SEL_W    = (RW+1)'(34);
    localparam logic [RW:0] SEL_NONE = (RW+1)'(35);
    localparam int CNT_W = (MEM_CYCLES > 1) ? $clog2(MEM_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_CYCLES - 1);

    if (MEM_CYCLES < 1 || STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_params
        $error("decode_sequencer: MEM_CYCLES must be >= 1 and STACK_DEPTH a power of two >= 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, MEMHOLD} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] hold_cnt;
    logic             accept;
    logic             done;

    logic [3:0]       d_aluc;
    logic             d_kmux, d_mr, d_mw, d_pcload, d_illegal;
    logic [RW:0]      d_selb, d_selc;
    logic [6:0]       d_type;
    logic [PC_W-1:0]  d_target;

`ifdef EV22_CALL_STACK_EN
    localparam int PTR_W = $clog2(STACK_DEPTH);
    logic [PC_W-1:0]  stack_mem [STACK_DEPTH];
    logic [PTR_W:0]   sp;
    logic [PTR_W-1:0] top_idx;
    logic             stack_empty, stack_full;
    logic             d_push, d_pop;
    logic             push_q, pop_q, stack_err_q;
    logic [PC_W-1:0]  ret_addr_q;

    assign top_idx     = PTR_W'(sp - (PTR_W+1)'(1));
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == (PTR_W+1)'(STACK_DEPTH));
    assign stack_err   = stack_err_q;
`else
    assign stack_err   = 1'b0;
`endif

    assign accept      = instr_valid & instr_ready;
    assign instr_ready = (state == IDLE);
    assign done        = (state == ISSUE) || (state == MEMHOLD && hold_cnt == '0);
    assign ctrl_valid  = done;
    assign SH          = 2'b00;

    // Decode the presented opcode into the control word that will be latched on accept.
    always_comb begin
        d_aluc    = 4'b0000;
        d_kmux    = 1'b0;
        d_mr      = 1'b0;
        d_mw      = 1'b0;
        d_selb    = '0;
        d_selc    = SEL_NONE;
        d_type    = 7'b0000000;
        d_pcload  = 1'b0;
        d_target  = '0;
        d_illegal = 1'b0;
`ifdef EV22_CALL_STACK_EN
        d_push    = 1'b0;
        d_pop     = 1'b0;
`endif
        casez (OPCODE)
            8'b00100???:              d_type = 7'b1000000;
            8'b00101???, 8'b00110???: d_type = 7'b1000001;
            8'b00111???:              d_type = 7'b1010000;
            8'b000100??: begin d_mw = 1'b1; d_type = 7'b0000001; end
            8'b000101??: begin d_mr = 1'b1; d_type = 7'b0000010; end
            8'b000110??: begin
                d_aluc = 4'b0101; d_selb = SEL_W; d_selc = {1'b0, Ri}; d_type = 7'b0111101;
            end
            8'b000111??: begin
                d_type   = 7'b1000000;
                d_pcload = 1'b1;
                d_target = pc + PC_W'(OPCODE[1:0]);
`ifdef EV22_CALL_STACK_EN
                d_push   = 1'b1;
`endif
            end
            8'b000010??: begin d_selb = SEL_W; d_selc = {1'b0, Ri}; d_type = 7'b0001100; end
            8'b000011??: begin
                d_aluc = 4'b0001; d_selb = SEL_W; d_selc = {1'b0, Ri}; d_type = 7'b0001001;
            end
            8'h04: begin d_kmux = 1'b1; d_selc = SEL_W; d_type = 7'b0000010; end
            8'h05: begin d_aluc = 4'b0111; d_kmux = 1'b1; d_selb = SEL_W; d_selc = SEL_W; d_type = 7'b0000011; end
            8'h06: begin d_aluc = 4'b0110; d_kmux = 1'b1; d_selb = SEL_W; d_selc = SEL_W; d_type = 7'b0000011; end
            8'h07: begin d_aluc = 4'b0101; d_kmux = 1'b1; d_selb = SEL_W; d_selc = SEL_W; d_type = 7'b0110011; end
            8'h02, 8'h44: begin d_selc = SEL_W; d_type = 7'b0000110; end
            8'h42: begin d_aluc = 4'b0111; d_selb = SEL_W; d_selc = SEL_W; d_type = 7'b0000111; end
            8'h03: begin d_aluc = 4'b0110; d_selb = SEL_W; d_selc = SEL_W; d_type = 7'b0000111; end
            8'h43: begin d_aluc = 4'b0101; d_selb = SEL_W; d_selc = SEL_W; d_type = 7'b0110111; end
            8'h00: begin d_aluc = 4'b0011; d_selb = SEL_W; d_selc = SEL_W; d_type = 7'b0000011; end
            8'h40: begin d_aluc = 4'b1011; d_type = 7'b0100000; end
            8'h01: begin d_aluc = 4'b1100; d_type = 7'b0100000; end
`ifdef EV22_CALL_STACK_EN
            8'h41: begin
                d_type   = 7'b1000000;
                d_pcload = 1'b1;
                d_target = stack_empty ? '0 : stack_mem[top_idx];
                d_pop    = 1'b1;
            end
`endif
            default: d_illegal = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic: MOM instructions detour through MEMHOLD, everything else pulses once in ISSUE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (d_mr | d_mw) ? MEMHOLD : ISSUE;
            ISSUE:   state_next = IDLE;
            MEMHOLD: if (hold_cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory hold counter, loaded on accept and run down to zero while in MEMHOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                               hold_cnt <= '0;
        else if (accept)                            hold_cnt <= CNT_LOAD;
        else if (state == MEMHOLD && hold_cnt != '0) hold_cnt <= hold_cnt - CNT_W'(1);
    end

    // Control word register: loaded on accept and held; only MR/MW drop once the instruction completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ALUC      <= '0;
            KMux      <= 1'b0;
            MR        <= 1'b0;
            MW        <= 1'b0;
            Sel_A     <= '0;
            Sel_B     <= '0;
            Sel_C     <= SEL_NONE;
            Type      <= '0;
            pc_load   <= 1'b0;
            pc_target <= '0;
            illegal   <= 1'b0;
        end else if (accept) begin
            ALUC      <= d_aluc;
            KMux      <= d_kmux;
            MR        <= d_mr;
            MW        <= d_mw;
            Sel_A     <= Rj;
            Sel_B     <= d_selb;
            Sel_C     <= d_selc;
            Type      <= d_type;
            pc_load   <= d_pcload;
            pc_target <= d_target;
            illegal   <= d_illegal;
        end else if (done) begin
            MR        <= 1'b0;
            MW        <= 1'b0;
        end
    end

`ifdef EV22_CALL_STACK_EN
    // Stack pointer and sticky error: the pending push/pop is captured on accept and committed with ctrl_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp          <= '0;
            stack_err_q <= 1'b0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            ret_addr_q  <= '0;
        end else begin
            if (accept) begin
                push_q     <= d_push;
                pop_q      <= d_pop;
                ret_addr_q <= pc + PC_W'(1);
            end
            if (done && push_q) begin
                if (stack_full) stack_err_q <= 1'b1;
                else            sp <= sp + (PTR_W+1)'(1);
            end
            if (done && pop_q) begin
                if (stack_empty) stack_err_q <= 1'b1;
                else             sp <= sp - (PTR_W+1)'(1);
            end
        end
    end

    // Stack storage; entries above the pointer are never read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (done && push_q && !stack_full) stack_mem[sp[PTR_W-1:0]] <= ret_addr_q;
    end
`endif

endmodule

// File: doc/decode_sequencer.md
# decode_sequencer

Registered, handshaked successor to the EV22 combinational instruction decoder. Accepts one instruction per handshake, emits a registered control word for the datapath, and stretches memory operations over a parametrised number of cycles. It also owns the BSR/RET return-address stack and flags illegal opcodes. It sits between the fetch stage (instruction register, PC) and the datapath/ALU/memory controls.

## Interface
Parameters:
- RW, 5: register index width; Sel_A is RW bits, Sel_B/Sel_C are RW+1 bits.
- PC_W, 8: program counter width.
- STACK_DEPTH, 4: return-address stack entries, power of two, ≥2.
- MEM_CYCLES, 2: cycles MR/MW are held for a MOM instruction, ≥1.

Ports:
- clk, in, 1: sole clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- instr_valid, in, 1: fetch presents an instruction.
- instr_ready, out, 1: decoder can accept an instruction.
- OPCODE, in, 8: opcode.
- Ri, in, RW: destination index.
- Rj, in, RW: source index.
- pc, in, PC_W: address of the presented instruction.
- ctrl_valid, out, 1: control word is valid this cycle (one-cycle pulse per instruction).
- ALUC, out, 4: ALU function.
- SH, out, 2: shifter control.
- KMux, out, 1: immediate select.
- MR, out, 1: memory read.
- MW, out, 1: memory write.
- Sel_A, out, RW: A-bus source.
- Sel_B, out, RW+1: B-bus select.
- Sel_C, out, RW+1: write-back select. 34 = W, 35 = none.
- Type, out, 7: instruction class for flag and branch logic.
- pc_load, out, 1: PC redirect (BSR/RET), qualified by ctrl_valid.
- pc_target, out, PC_W: redirect address.
- illegal, out, 1: undefined opcode, qualified by ctrl_valid.
- stack_err, out, 1: sticky overflow/underflow flag; cleared only by reset.

## Operation
- Reset values: every output is 0 except Sel_C, which resets to 35. instr_ready resets to 1. The FSM resets to IDLE and the stack pointer to 0.
- FSM states: IDLE, ISSUE, MEMHOLD.
  - IDLE: instr_ready=1. On instr_valid, latch the decoded word and go to ISSUE, or to MEMHOLD if the opcode is a MOM.
  - ISSUE: ctrl_valid=1 for one cycle, instr_ready=0, then go to IDLE.
  - MEMHOLD: MR or MW stays asserted and a counter runs from MEM_CYCLES-1 down to 0. At 0, ctrl_valid=1, then go to IDLE.
- Decode table (OPCODE → ALUC, KMux, MR, MW, Sel_B, Sel_C, Type). Any field not listed is 0. Sel_A=Rj always.
  - 00100xxx JMP: Sel_C=35, Type 1000000.
  - 00101xxx JZE and 00110xxx JNE: Sel_C=35, Type 1000001.
  - 00111xxx JCY: Sel_C=35, Type 1010000.
  - 000100yy MOM Y,W: MW=1, Sel_C=35, Type 0000001.
  - 000101yy MOM W,Y: MR=1, Sel_C=35, Type 0000010.
  - 000110ii ADW: ALUC 0101, Sel_B=34, Sel_C={0,Ri}, Type 0111101.
  - 000111ss BSR: Sel_C=35, Type 1000000, pc_load=1, pc_target=pc+ss. Pushes pc+1 onto the stack.
  - 000010ii MOV Ri,Rj: Sel_B=34, Sel_C={0,Ri}, Type 0001100.
  - 000011ii MOV Ri,W: ALUC 0001, Sel_B=34, Sel_C={0,Ri}, Type 0001001.
  - 0x04 MOK: KMux=1, Sel_C=34, Type 0000010.
  - 0x05 ANK: ALUC 0111, KMux=1, Sel_B=34, Sel_C=34, Type 0000011.
  - 0x06 ORK: ALUC 0110, KMux=1, Sel_B=34, Sel_C=34, Type 0000011.
  - 0x07 ADK: ALUC 0101, KMux=1, Sel_B=34, Sel_C=34, Type 0110011.
  - 0x02 MOV W,Rj and 0x44 MOV W,PIj: Sel_C=34, Type 0000110.
  - 0x42 ANR: ALUC 0111, Sel_B=34, Sel_C=34, Type 0000111.
  - 0x03 ORR: ALUC 0110, Sel_B=34, Sel_C=34, Type 0000111.
  - 0x43 ADR: ALUC 0101, Sel_B=34, Sel_C=34, Type 0110111.
  - 0x00 CPL: ALUC 0011, Sel_B=34, Sel_C=34, Type 0000011.
  - 0x40 CLR CY: ALUC 1011, Sel_C=35, Type 0100000.
  - 0x01 SET CY: ALUC 1100, Sel_C=35, Type 0100000.
  - 0x41 RET: Sel_C=35, Type 1000000, pc_load=1, pc_target=popped value.
  - Any other opcode: all fields 0, Sel_C=35, illegal=1. No state side effects.
- Arithmetic: pc+ss and pc+1 are computed modulo 2^PC_W, so they wrap.
- Stack boundaries:
  - Push when full: push is dropped, stack_err set, PC redirect still occurs.
  - Pop when empty: pc_target=0, stack_err set, pointer unchanged.

## Timing
- Handshake: accept when instr_valid & instr_ready. The upstream side holds OPCODE/Ri/Rj/pc stable until accepted.
- Non-memory instruction: accepted in cycle N, ctrl_valid in N+1, instr_ready high again in N+2. Throughput is 1 per 2 cycles.
- MOM instruction: MR/MW high in cycles N+1 … N+MEM_CYCLES, ctrl_valid in N+MEM_CYCLES, instr_ready back in N+MEM_CYCLES+1.
- Control outputs are registered and stay at their last value between pulses. Only MR and MW return to 0 outside ISSUE/MEMHOLD.
- Stack push/pop commits on the ctrl_valid cycle.
- reset_n low at any point, including mid-MEMHOLD: immediate return to reset values. An in-flight instruction is discarded and the stack is emptied.

## Configuration
- EV22_CALL_STACK_EN defined: return stack, BSR push, RET pop and stack_err are implemented as above.
- EV22_CALL_STACK_EN undefined: no stack storage.
  - BSR still redirects to pc+ss.
  - RET decodes as illegal (illegal=1, pc_load=0).
  - stack_err is tied to 0.

## Test plan
- Reset mid-MEMHOLD (MEM_CYCLES=3, MOM 0x14 accepted, reset_n pulsed low in 2nd hold cycle) → MR=0, Sel_C=35, instr_ready=1 immediately; no ctrl_valid.
- ADW 0x18 with Ri=5, Rj=9 → ctrl_valid one cycle later with ALUC=0101, Sel_A=9, Sel_B=34, Sel_C=5, Type=0111101; instr_ready low for exactly 1 cycle.
- MOM 0x10 with MEM_CYCLES=2 → MW high 2 cycles, ctrl_valid only in 2nd, next accept on 3rd.
- BSR 0x1E at pc=0xFF, then RET → first pc_target=0x01 (wrap), RET pc_target=0x00 (pc+1 wrapped); stack_err=0.
- Five BSRs (STACK_DEPTH=4), then five RETs → stack_err set on 5th push; the 5th RET returns 0 and stack_err stays 1.
- Opcodes 0x80, 0xFF → illegal=1, Sel_C=35, MR=MW=0, stack pointer unchanged; with EV22_CALL_STACK_EN undefined, 0x41 → illegal=1.
